// File: rtl/cpu_types_pkg.sv
// ============================================================================
//  Module   : cpu_types_pkg
//  Brief    : Shared types and constants for the 5-stage pipeline control path.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } hzc_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t C_CTRL_HOLD     = pipe_ctrl_t'(8'b0000_0000);
    localparam pipe_ctrl_t C_CTRL_RUN      = pipe_ctrl_t'(8'b1111_1000);
    localparam pipe_ctrl_t C_CTRL_REDIRECT = pipe_ctrl_t'(8'b1111_1111);
    // Load-use bubble: freeze PC and IF/ID, squash the ID instruction into EX.
    localparam pipe_ctrl_t C_CTRL_BUBBLE   = pipe_ctrl_t'(8'b0011_1010);

    // A flush only takes effect through its register's enable; drop any
    // flush whose enable is low so the pair can never disagree.
    function automatic pipe_ctrl_t gate_flushes(input pipe_ctrl_t c);
        pipe_ctrl_t r;
        r             = c;
        r.ifid_flush  = c.ifid_flush  & c.ifid_en;
        r.idex_flush  = c.idex_flush  & c.idex_en;
        r.exmem_flush = c.exmem_flush & c.exmem_en;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_control_if.sv
// ============================================================================
//  Module   : pipeline_control_if
//  Brief    : Pipeline-register enables and flushes from the hazard controller.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface pipeline_control_if;

    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;

    modport master (
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, exmem_flush
    );

    modport slave (
        input pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input ifid_flush, idex_flush, exmem_flush
    );

endinterface

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
//  Module   : sat_counter
//  Brief    : W-bit event counter that sticks at all-ones instead of wrapping.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 16
) (
    input  wire logic         CLK,
    input  wire logic         RST,
    input  wire logic         inc,
    output logic [W-1:0]      count
);

    logic [W-1:0] r_count;
    logic         w_at_max;

    assign w_at_max = &r_count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else if (inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
// ============================================================================
//  Module   : pipeline_hazard_controller
//  Brief    : Stall/flush sequencing for the 5-stage MIPS pipeline, with
//             saturating stall and redirect performance counters.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_controller
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  wire logic             CLK,
    input  wire logic             RST,
    input  wire logic             ihit,
    input  wire logic             dhit,
    input  wire logic             dmem_req_mem,
    input  wire logic             memread_ex,
    input  wire logic [4:0]       wsel_ex,
    input  wire logic [4:0]       rs_id,
    input  wire logic [4:0]       rt_id,
    input  wire logic             use_rt_id,
    input  wire logic             branch_taken_mem,
    input  wire logic             halt_wb,
    pipeline_control_if.master    ctrl,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    hzc_state_t r_state;
    hzc_state_t w_state_next;
    logic       r_halted;

    logic       w_dok;
    logic       w_lu;
    logic       w_advance;
    pipe_ctrl_t w_tail_ctrl;
    pipe_ctrl_t w_ctrl;
    logic       w_redirect;
    logic       w_halt_entry;
    logic       w_stall_inc;

    assign w_dok     = !dmem_req_mem || dhit;
    assign w_lu      = memread_ex && (wsel_ex != REG_ZERO) &&
                       ((wsel_ex == rs_id) || (use_rt_id && (wsel_ex == rt_id)));
    assign w_advance = ihit && w_dok;

    // Lower half of the priority list, shared by RUN and the DWAIT exit.
    // A redirect squashes the ID instruction, so load-use is moot then.
    always_comb begin
        w_tail_ctrl = C_CTRL_RUN;
        if (branch_taken_mem) begin
            w_tail_ctrl = C_CTRL_REDIRECT;
        end else if (w_lu) begin
            w_tail_ctrl = C_CTRL_BUBBLE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_halt_entry) begin
                r_halted <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ctrl       = C_CTRL_HOLD;
        w_redirect   = 1'b0;
        w_halt_entry = 1'b0;
        case (r_state)
            RUN: begin
                if (halt_wb) begin
                    w_state_next = HALT;
                    w_halt_entry = 1'b1;
                end else if (!w_dok) begin
                    w_state_next = DWAIT;
                end else if (w_advance) begin
                    w_ctrl     = w_tail_ctrl;
                    w_redirect = branch_taken_mem;
                end
            end
            DWAIT: begin
                // With ihit low, go back to RUN idle and let it wait for fetch.
                if (dhit) begin
                    w_state_next = RUN;
                    if (ihit) begin
                        w_ctrl     = w_tail_ctrl;
                        w_redirect = branch_taken_mem;
                    end
                end
            end
            HALT: begin
                w_state_next = HALT;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
        if (RST) begin
            w_ctrl     = C_CTRL_HOLD;
            w_redirect = 1'b0;
        end
        w_ctrl = gate_flushes(w_ctrl);
    end

    assign w_stall_inc = ((r_state == RUN) || (r_state == DWAIT)) &&
                         !w_ctrl.pc_en && !w_halt_entry;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (w_redirect),
        .count (flush_cnt)
    );

    assign ctrl.pc_en       = w_ctrl.pc_en;
    assign ctrl.ifid_en     = w_ctrl.ifid_en;
    assign ctrl.idex_en     = w_ctrl.idex_en;
    assign ctrl.exmem_en    = w_ctrl.exmem_en;
    assign ctrl.memwb_en    = w_ctrl.memwb_en;
    assign ctrl.ifid_flush  = w_ctrl.ifid_flush;
    assign ctrl.idex_flush  = w_ctrl.idex_flush;
    assign ctrl.exmem_flush = w_ctrl.exmem_flush;

    assign halted = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
// ============================================================================
//  Module   : tb_pipeline_hazard_controller
//  Brief    : Directed bench with a rule-level reference model of the hazard
//             controller compared against the DUT on every falling edge.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_controller;

    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             ihit, dhit, dmem_req_mem, memread_ex, use_rt_id;
    logic             branch_taken_mem, halt_wb;
    logic [4:0]       wsel_ex, rs_id, rt_id;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipeline_control_if ctrl_if ();

    pipeline_hazard_controller #(.CNT_W(CNT_W)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .ihit             (ihit),
        .dhit             (dhit),
        .dmem_req_mem     (dmem_req_mem),
        .memread_ex       (memread_ex),
        .wsel_ex          (wsel_ex),
        .rs_id            (rs_id),
        .rt_id            (rt_id),
        .use_rt_id        (use_rt_id),
        .branch_taken_mem (branch_taken_mem),
        .halt_wb          (halt_wb),
        .ctrl             (ctrl_if),
        .halted           (halted),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Modes: 0 running, 1 waiting on D-cache, 2 halted.
    // Actions: what the pipeline does this cycle.
    localparam int A_HOLD = 0, A_GO = 1, A_SQUASH = 2, A_BUBBLE = 3, A_HALTING = 4, A_FROZEN = 5;

    int m_mode   = 0;
    int m_stall  = 0;
    int m_flush  = 0;
    bit m_halted = 1'b0;

    function automatic int action_of(input int mode, input bit halt, input bit dok,
                                     input bit ih, input bit dh, input bit br, input bit lu);
        bit go;
        if (mode == 2) return A_FROZEN;
        if (mode == 0) begin
            if (halt) return A_HALTING;
            go = dok && ih;
        end else begin
            go = dh && ih;
        end
        if (!go) return A_HOLD;
        if (br)  return A_SQUASH;
        if (lu)  return A_BUBBLE;
        return A_GO;
    endfunction

    function automatic int next_mode_of(input int mode, input bit halt, input bit dok, input bit dh);
        if (mode == 2) return 2;
        if (mode == 1) return dh ? 0 : 1;
        if (halt) return 2;
        return dok ? 0 : 1;
    endfunction

    // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, exmem_flush}
    function automatic logic [7:0] outputs_of(input int a);
        case (a)
            A_GO:     return 8'b11111_000;
            A_SQUASH: return 8'b11111_111;
            A_BUBBLE: return 8'b00111_010;
            default:  return 8'b00000_000;
        endcase
    endfunction

    logic m_dok, m_lu;
    int   m_act;
    assign m_dok = !dmem_req_mem || dhit;
    assign m_lu  = memread_ex && (wsel_ex != 5'd0) &&
                   ((wsel_ex == rs_id) || (use_rt_id && (wsel_ex == rt_id)));
    assign m_act = action_of(m_mode, halt_wb, m_dok, ihit, dhit, branch_taken_mem, m_lu);

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_mode   <= 0;
            m_stall  <= 0;
            m_flush  <= 0;
            m_halted <= 1'b0;
        end else begin
            m_mode <= next_mode_of(m_mode, halt_wb, m_dok, dhit);
            if ((m_act == A_HOLD || m_act == A_BUBBLE) && m_stall < SAT) m_stall <= m_stall + 1;
            if (m_act == A_SQUASH && m_flush < SAT) m_flush <= m_flush + 1;
            if (m_act == A_HALTING) m_halted <= 1'b1;
        end
    end

    logic [7:0] dut_vec;
    assign dut_vec = {ctrl_if.pc_en, ctrl_if.ifid_en, ctrl_if.idex_en, ctrl_if.exmem_en,
                      ctrl_if.memwb_en, ctrl_if.ifid_flush, ctrl_if.idex_flush, ctrl_if.exmem_flush};

    always @(negedge CLK) begin
        check("ctrl_vec",  32'(dut_vec),   32'(RST ? 8'h00 : outputs_of(m_act)));
        check("halted",    32'(halted),    32'(m_halted));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    end

    // ---------------- stimulus ----------------
    task automatic defaults();
        ihit = 1'b1; dhit = 1'b0; dmem_req_mem = 1'b0; memread_ex = 1'b0; use_rt_id = 1'b0;
        branch_taken_mem = 1'b0; halt_wb = 1'b0; wsel_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        defaults();
        RST = 1'b1;
        #2;
        RST = 1'b0;
        #1;
    endtask

    initial begin
        defaults();
        RST = 1'b1;
        step(2);
        #2;
        check("rst_pc_en",     32'(ctrl_if.pc_en),      0);
        check("rst_memwb_en",  32'(ctrl_if.memwb_en),   0);
        check("rst_stall_cnt", 32'(stall_cnt),          0);
        RST = 1'b0;
        step(1);

        // Reset in the middle of a D-cache wait
        do_reset();
        dmem_req_mem = 1'b1;
        step(3);
        check("dwait_pre_rst_stall", 32'(stall_cnt), 3);
        RST = 1'b1;
        #1;
        check("rst_dwait_pc_en", 32'(ctrl_if.pc_en), 0);
        check("rst_dwait_stall", 32'(stall_cnt),     0);
        dmem_req_mem = 1'b0;
        #2;
        RST = 1'b0;
        #1;
        check("post_rst_pc_en",    32'(ctrl_if.pc_en),    1);
        check("post_rst_memwb_en", 32'(ctrl_if.memwb_en), 1);
        step(1);

        // Load-use on rs, then a load to $zero, then via rt
        do_reset();
        memread_ex = 1'b1; wsel_ex = 5'd8; rs_id = 5'd8;
        #2;
        check("lu_pc_en",      32'(ctrl_if.pc_en),      0);
        check("lu_ifid_en",    32'(ctrl_if.ifid_en),    0);
        check("lu_idex_flush", 32'(ctrl_if.idex_flush), 1);
        step(1);
        memread_ex = 1'b0;
        #2;
        check("lu_clear_pc_en", 32'(ctrl_if.pc_en), 1);
        check("lu_stall_cnt",   32'(stall_cnt),     1);
        step(1);
        memread_ex = 1'b1; wsel_ex = 5'd0; rs_id = 5'd0;
        #2;
        check("lu_zero_pc_en", 32'(ctrl_if.pc_en), 1);
        step(1);
        wsel_ex = 5'd9; rs_id = 5'd3; rt_id = 5'd9; use_rt_id = 1'b1;
        #2;
        check("lu_rt_pc_en", 32'(ctrl_if.pc_en), 0);
        step(1);
        use_rt_id = 1'b0;
        #2;
        check("lu_rt_unused_pc_en", 32'(ctrl_if.pc_en), 1);
        step(1);

        // D-cache wait of three cycles
        do_reset();
        dmem_req_mem = 1'b1;
        #2;
        check("dw_pc_en", 32'(ctrl_if.pc_en), 0);
        step(3);
        dhit = 1'b1;
        #2;
        check("dw_hit_pc_en",  32'(ctrl_if.pc_en), 1);
        check("dw_stall_cnt",  32'(stall_cnt),     3);
        step(1);
        dmem_req_mem = 1'b0; dhit = 1'b0;
        #2;
        check("dw_back_run", 32'(ctrl_if.pc_en), 1);
        // dhit without ihit leaves DWAIT without advancing
        dmem_req_mem = 1'b1;
        step(1);
        dhit = 1'b1; ihit = 1'b0;
        #2;
        check("dw_noihit_pc_en", 32'(ctrl_if.pc_en), 0);
        step(1);
        dmem_req_mem = 1'b0; dhit = 1'b0;
        step(1);
        ihit = 1'b1;
        // Redirect held behind a D-cache wait
        dmem_req_mem = 1'b1; branch_taken_mem = 1'b1;
        #2;
        check("dw_br_flush_blocked", 32'(ctrl_if.exmem_flush), 0);
        step(1);
        dhit = 1'b1;
        #2;
        check("dw_br_flush", 32'(ctrl_if.exmem_flush), 1);
        step(1);
        defaults();
        #2;
        check("dw_br_flush_cnt", 32'(flush_cnt), 1);
        step(1);

        // Redirect and load-use in the same cycle
        do_reset();
        branch_taken_mem = 1'b1; memread_ex = 1'b1; wsel_ex = 5'd8; rs_id = 5'd8;
        #2;
        check("br_lu_vec", 32'(dut_vec), 32'h0FF);
        step(1);
        defaults();
        #2;
        check("br_lu_flush_cnt", 32'(flush_cnt), 1);
        check("br_lu_stall_cnt", 32'(stall_cnt), 0);
        step(1);

        // Halt while a D-cache access is pending, then a frozen pipeline
        do_reset();
        memread_ex = 1'b1; wsel_ex = 5'd4; rs_id = 5'd4;
        step(1);
        defaults();
        dmem_req_mem = 1'b1; halt_wb = 1'b1;
        #2;
        check("halt_memwb_en", 32'(ctrl_if.memwb_en), 0);
        step(1);
        #2;
        check("halt_halted", 32'(halted),    1);
        check("halt_stall",  32'(stall_cnt), 1);
        for (int i = 0; i < 10; i++) begin
            halt_wb = 1'b0; dmem_req_mem = 1'b0; dhit = 1'b1;
            ihit = i[0]; branch_taken_mem = (i % 3 == 0);
            #2;
            check("halt_frozen_vec", 32'(dut_vec),   0);
            check("halt_frozen_stl", 32'(stall_cnt), 1);
            step(1);
        end

        // Stall counter saturation
        do_reset();
        ihit = 1'b0;
        step(20);
        #2;
        check("sat_stall_cnt", 32'(stall_cnt), 15);
        step(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences pipeline-register enables and flushes for the 5-stage MIPS pipeline.
- Arbitrates between I-cache wait, D-cache wait, load-use stall, branch/jump redirect and halt.
- Complements the forwarding unit: it covers only the hazards that forwarding cannot resolve.
- Keeps saturating stall and flush performance counters.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- CLK  in  1  pipeline clock.
- RST  in  1  asynchronous reset, active-high.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- dmem_req_mem  in  1  MEM-stage instruction issues dREN or dWEN.
- memread_ex  in  1  EX-stage instruction is a load.
- wsel_ex  in  5  EX-stage destination register.
- rs_id  in  5  ID-stage source register rs.
- rt_id  in  5  ID-stage source register rt.
- use_rt_id  in  1  ID-stage instruction reads rt.
- branch_taken_mem  in  1  taken branch or jump resolved in MEM.
- halt_wb  in  1  HALT instruction in WB.
- pc_en  out  1  PC update enable.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline-register enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  synchronous bubble insert on the next edge, gated by the matching enable.
- halted  out  1  registered halt status.
- stall_cnt  out  CNT_W  cycles in which pc_en was 0 while in RUN or DWAIT.
- flush_cnt  out  CNT_W  number of redirects taken.

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high. It forces state RUN, halted=0 and both counters to 0.
- Outputs during reset: all enables 0, all flushes 0.
- States: RUN, DWAIT, HALT (enum in the shared package).
- dok = !dmem_req_mem || dhit.
- lu = memread_ex && wsel_ex!=0 && (wsel_ex==rs_id || (use_rt_id && wsel_ex==rt_id)).
- advance = ihit && dok.
- RUN, priority high to low:
  1. halt_wb: memwb_en=0, all other enables 0; next state HALT; halted is set at that edge.
  2. !dok: all enables 0; next state DWAIT.
  3. !ihit: all enables 0; stay in RUN.
  4. branch_taken_mem: all enables 1; ifid_flush, idex_flush and exmem_flush all 1; flush_cnt+1. The load-use check is ignored because the ID instruction is squashed.
  5. lu: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1, memwb_en=1. This is a one-cycle bubble. The hazard clears on the next cycle because the load moves to MEM; the forwarding unit then supplies the value from WB.
  6. Otherwise all enables 1 and no flushes.
- DWAIT:
  - All enables 0 until dhit.
  - On the dhit cycle, if ihit is also 1, apply the RUN priority list from item 4 down, then return to RUN.
  - If ihit is 0, return to RUN without advancing. RUN then waits for ihit under rule 3.
- HALT:
  - All enables 0 and halted=1; the state is terminal until RST.
  - Counters freeze.
- Counters:
  - They saturate at all-ones and do not wrap.
  - stall_cnt increments in every RUN or DWAIT cycle with pc_en=0, excluding the halt-entry cycle.
- Simultaneous events:
  - halt_wb beats everything.
  - A D-cache wait beats a redirect, so the redirect is taken after dhit because branch_taken_mem is held by the stalled EX/MEM register.
  - A redirect beats load-use.
- Flush outputs are never asserted while their enable is 0.
- Outputs are combinational from state and inputs. halted and the counters are registered.

Decomposition:
- cpu_types_pkg gains the enum hzc_state_t {RUN, DWAIT, HALT} and the constant REG_ZERO = 5'd0.
- A control interface, pipeline_control_if, carries the enables and flushes, with a modport for this block.
- One sub-module, sat_counter (parameter W; ports CLK, RST, inc, count), instantiated twice.

Test Plan:
- Reset mid-DWAIT: assert RST while dmem_req_mem=1 and dhit=0 -> enables 0 immediately, state RUN, counters 0; after release with ihit=1 and dok=1, all enables 1.
- Load-use: memread_ex=1, wsel_ex=8, rs_id=8, ihit=1, dmem_req_mem=0 -> pc_en=0, ifid_en=0, idex_flush=1 for exactly one cycle; stall_cnt=1. A repeat with wsel_ex=0 -> no stall.
- D-cache wait: dmem_req_mem=1, dhit low for 3 cycles then high, ihit=1 -> enables 0 for 3 cycles, then 1; stall_cnt=3; state RUN→DWAIT→RUN.
- Redirect plus load-use in the same cycle: branch_taken_mem=1, lu=1 -> all enables 1, three flushes 1, flush_cnt=1, no load-use bubble.
- Halt: halt_wb=1 while dhit pending -> next cycle halted=1, all enables 0 for 10 further cycles, counters unchanged.
- Saturation: CNT_W=4, hold ihit=0 for 20 cycles -> stall_cnt stops at 15.
